// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the Hack-style CPU control sequencer.
// State encodings are visible on state_o, so they are fixed here.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MWRITE = 3'd5,
    ST_COMMIT = 3'd6,
    ST_FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] JMP_NULL   = 3'b000;
  localparam logic [2:0] JMP_JGT    = 3'b001;
  localparam logic [2:0] JMP_JEQ    = 3'b010;
  localparam logic [2:0] JMP_JGE    = 3'b011;
  localparam logic [2:0] JMP_JLT    = 3'b100;
  localparam logic [2:0] JMP_JNE    = 3'b101;
  localparam logic [2:0] JMP_JLE    = 3'b110;
  localparam logic [2:0] JMP_ALWAYS = 3'b111;

  localparam int IR_CI = 15;
  localparam int IR_A  = 12;
  localparam int IR_D1 = 5;
  localparam int IR_D2 = 4;
  localparam int IR_D3 = 3;

  // States that own the memory port and therefore run the wait counter.
  function automatic logic is_req_state(input state_t s);
    logic r;
    case (s)
      ST_FETCH, ST_MEMRD, ST_MWRITE: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_seq_jmp_eval.sv
// Jump-condition evaluator: maps the C-instruction jump field and the
// ALU zero/negative flags to a single take-the-jump bit.
module jmp_eval
  import cpu_pkg::*;
(
  input  logic [2:0] jmp_i,
  input  logic       zr_i,
  input  logic       ng_i,
  output logic       cond_o
);

  logic pos_s;
  assign pos_s = ~zr_i & ~ng_i;

  // Decode the jump field against the result sign/zero.
  always_comb begin
    cond_o = 1'b0;
    case (jmp_i)
      JMP_NULL:   cond_o = 1'b0;
      JMP_JGT:    cond_o = pos_s;
      JMP_JEQ:    cond_o = zr_i;
      JMP_JGE:    cond_o = zr_i | pos_s;
      JMP_JLT:    cond_o = ng_i;
      JMP_JNE:    cond_o = ~zr_i;
      JMP_JLE:    cond_o = zr_i | ng_i;
      JMP_ALWAYS: cond_o = 1'b1;
      default:    cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle control sequencer for the 16-bit Hack-style CPU.
// Optional macro CPU_SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        m_load,
  output logic        a_load,
  output logic        a_src,
  output logic        d_load,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        busy,
  output logic        fault,
`ifdef CPU_SEQ_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic [2:0]  state_o
);

  localparam logic             TMO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  state_t           ack_nxt_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             tmo_hit_s;
  logic             cond_s;
  logic             unused_ir_s;

  assign unused_ir_s = ^{ir[14:13], ir[11:6]};

  jmp_eval u_jmp_eval (
    .jmp_i  (ir[2:0]),
    .zr_i   (alu_zr),
    .ng_i   (alu_ng),
    .cond_o (cond_s)
  );

  assign cnt_inc_s = cnt_q + CNT_W'(1);
  // The expiring wait cycle is the one whose increment reaches the limit.
  assign tmo_hit_s = TMO_EN && (cnt_inc_s == TMO_LIM);

  // State and wait-counter registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    ack_nxt_s = state_q;
    cnt_d     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    m_load    = 1'b0;
    a_load    = 1'b0;
    a_src     = 1'b0;
    d_load    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_load   = mem_ack;
        ack_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (!ir[IR_CI]) begin
          state_d = ST_COMMIT;
        end else if (ir[IR_A]) begin
          state_d = ST_MEMRD;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEMRD: begin
        addr_sel  = 1'b1;
        m_load    = mem_ack;
        ack_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        if (ir[IR_D3]) begin
          state_d = ST_MWRITE;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_MWRITE: begin
        mem_we    = 1'b1;
        addr_sel  = 1'b1;
        ack_nxt_s = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (!ir[IR_CI]) begin
          a_load = 1'b1;
          a_src  = 1'b0;
          pc_inc = 1'b1;
        end else begin
          a_load  = ir[IR_D1];
          a_src   = 1'b1;
          d_load  = ir[IR_D2];
          pc_load = cond_s;
          pc_inc  = ~cond_s;
        end
        if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Shared handshake/timeout handling for every memory-owning state.
    if (is_req_state(state_q)) begin
      mem_req = 1'b1;
      if (mem_ack) begin
        state_d = ack_nxt_s;
      end else if (tmo_hit_s) begin
        state_d = ST_FAULT;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_inc_s;
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign fault   = (state_q == ST_FAULT);
  assign state_o = state_q;

`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Count one retirement per COMMIT cycle; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= 32'd0;
    end else if (state_q == ST_COMMIT) begin
      retire_q <= retire_q + 32'd1;
    end else begin
      retire_q <= retire_q;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// Directed self-checking bench for cpu_seq (TIMEOUT_CYC=4).
module tb_cpu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] ir;
  logic        alu_zr;
  logic        alu_ng;
  logic        mem_ack;
  logic        mem_req, mem_we, addr_sel, ir_load, m_load;
  logic        a_load, a_src, d_load, pc_load, pc_inc, busy, fault;
  logic [2:0]  state_o;
`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Expected jump result per code; bit k: k=0 positive, k=1 negative, k=2 zero.
  logic [2:0] jexp [8];

  logic [11:0] vec;
  assign vec = {mem_req, mem_we, addr_sel, ir_load, m_load, a_load,
                a_src, d_load, pc_load, pc_inc, busy, fault};

  always #5 clk = ~clk;

  cpu_seq #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .ir         (ir),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_load    (ir_load),
    .m_load     (m_load),
    .a_load     (a_load),
    .a_src      (a_src),
    .d_load     (d_load),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .busy       (busy),
    .fault      (fault),
`ifdef CPU_SEQ_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .state_o    (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive ack at the falling edge, then check state and outputs.
  task automatic nxt(input logic ack, input string tag, input logic [2:0] st, input logic [11:0] ev);
    @(negedge clk);
    mem_ack = ack;
    #1;
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_outs"}, 32'(vec), 32'(ev));
  endtask

  initial begin
    jexp = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    rst_n = 1'b0; run = 1'b0; ir = 16'h0000;
    alu_zr = 1'b0; alu_ng = 1'b0; mem_ack = 1'b0;
    #12;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_outs", 32'(vec), 32'd0);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    chk("reset_retire", retire_cnt, 32'd0);
`endif

    // A-instruction, zero-wait ack: FETCH, DECODE, COMMIT
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; ir = 16'h0005; mem_ack = 1'b1;
    nxt(1'b1, "a_fetch",  3'd1, 12'h902);
    nxt(1'b1, "a_decode", 3'd2, 12'h002);
    nxt(1'b1, "a_commit", 3'd6, 12'h046);
    nxt(1'b1, "a_next",   3'd1, 12'h902);

    // D=A: 4-cycle C-instruction, no memory operand
    ir = 16'hEC10;
    nxt(1'b1, "c_decode", 3'd2, 12'h002);
    nxt(1'b1, "c_exec",   3'd4, 12'h002);
    nxt(1'b1, "c_commit", 3'd6, 12'h036);

    // M=M-1 with two wait cycles per request
    nxt(1'b0, "m_fetch0", 3'd1, 12'h802);
    ir = 16'hFC88;
    nxt(1'b0, "m_fetch1", 3'd1, 12'h802);
    nxt(1'b1, "m_fetch2", 3'd1, 12'h902);
    nxt(1'b1, "m_decode", 3'd2, 12'h002);
    nxt(1'b0, "m_rd0",    3'd3, 12'hA02);
    nxt(1'b0, "m_rd1",    3'd3, 12'hA02);
    nxt(1'b1, "m_rd2",    3'd3, 12'hA82);
    nxt(1'b0, "m_exec",   3'd4, 12'h002);
    nxt(1'b0, "m_wr0",    3'd5, 12'hE02);
    nxt(1'b0, "m_wr1",    3'd5, 12'hE02);
    nxt(1'b1, "m_wr2",    3'd5, 12'hE02);
    nxt(1'b1, "m_commit", 3'd6, 12'h026);
    nxt(1'b1, "m_next",   3'd1, 12'h902);

    // Jump sweep: 8 codes x {positive, negative, zero}
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 3; k++) begin
        ir = 16'hE300 | 16'(c);
        alu_ng = (k == 1);
        alu_zr = (k == 2);
        nxt(1'b1, $sformatf("j%0d_%0d_decode", c, k), 3'd2, 12'h002);
        nxt(1'b1, $sformatf("j%0d_%0d_exec", c, k),   3'd4, 12'h002);
        nxt(1'b1, $sformatf("j%0d_%0d_commit", c, k), 3'd6,
            jexp[c][k] ? 12'h02A : 12'h026);
        nxt(1'b1, $sformatf("j%0d_%0d_fetch", c, k),  3'd1, 12'h902);
      end
    end
`ifdef CPU_SEQ_RETIRE_CNT_EN
    chk("retire_27", retire_cnt, 32'd27);
`endif

    // Reset asserted during MWRITE aborts with no commit
    ir = 16'hFC88; alu_zr = 1'b0; alu_ng = 1'b0;
    nxt(1'b1, "r_decode", 3'd2, 12'h002);
    nxt(1'b1, "r_rd",     3'd3, 12'hA82);
    nxt(1'b1, "r_exec",   3'd4, 12'h002);
    nxt(1'b0, "r_wr",     3'd5, 12'hE02);
    rst_n = 1'b0;
    #1;
    chk("r_rst_state", 32'(state_o), 32'd0);
    chk("r_rst_outs", 32'(vec), 32'd0);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    chk("r_rst_retire", retire_cnt, 32'd0);
`endif
    @(negedge clk);
    run = 1'b0; rst_n = 1'b1;
    nxt(1'b0, "r_idle", 3'd0, 12'h000);

    // Timeout: 4 unacknowledged FETCH cycles then sticky FAULT
    run = 1'b1; ir = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      nxt(1'b0, $sformatf("t_fetch%0d", i), 3'd1, 12'h802);
    end
    nxt(1'b0, "t_fault", 3'd7, 12'h001);
    nxt(1'b1, "t_hold0", 3'd7, 12'h001);
    nxt(1'b1, "t_hold1", 3'd7, 12'h001);
    rst_n = 1'b0;
    #1;
    chk("t_rst_state", 32'(state_o), 32'd0);
    chk("t_rst_outs", 32'(vec), 32'd0);

    // run dropped mid-instruction: completes, then stops in IDLE
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; mem_ack = 1'b1;
    nxt(1'b1, "d_fetch", 3'd1, 12'h902);
    run = 1'b0;
    nxt(1'b1, "d_decode", 3'd2, 12'h002);
    nxt(1'b1, "d_commit", 3'd6, 12'h046);
    nxt(1'b1, "d_idle0",  3'd0, 12'h000);
    nxt(1'b1, "d_idle1",  3'd0, 12'h000);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    chk("retire_1", retire_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
- Multi-cycle control sequencer for the 16-bit Hack-style CPU.
- Drives instruction fetch, operand read, memory write and register/PC commit over one shared single-port memory with a req/ack handshake.
- Evaluates the jump condition from the latched IR and the ALU flags.
- Sits between the IR, the A/D/M registers, the PC and the memory interface; contains no datapath itself.

Parameters:
- TIMEOUT_CYC, 255: max wait cycles for mem_ack per request; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = execute continuously; 0 = stop at next instruction boundary
- ir  in  16  latched instruction register contents
- alu_zr  in  1  ALU result zero flag
- alu_ng  in  1  ALU result negative flag
- mem_ack  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (ALU result to M[A])
- addr_sel  out  1  0 = address from PC, 1 = address from A
- ir_load  out  1  latch memory read data into IR
- m_load  out  1  latch memory read data into M operand register
- a_load  out  1  load A
- a_src  out  1  0 = A from IR[14:0], 1 = A from ALU
- d_load  out  1  load D from ALU
- pc_load  out  1  PC <= A
- pc_inc  out  1  PC <= PC+1
- busy  out  1  high in every state except IDLE and FAULT
- fault  out  1  sticky memory-timeout flag
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, every output 0. A reset mid-instruction aborts it with no commit.
- States: IDLE=0, FETCH=1, DECODE=2, MEMRD=3, EXEC=4, MWRITE=5, COMMIT=6, FAULT=7.
- Handshake:
  - mem_req, mem_we and addr_sel stay stable while mem_req=1.
  - A transfer completes on the rising edge where mem_req=1 and mem_ack=1; mem_req deasserts the next cycle.
  - mem_ack while mem_req=0 is ignored.
- IDLE: run=1 -> FETCH.
- FETCH: mem_req=1, addr_sel=0, ir_load=mem_ack. On ack -> DECODE.
- DECODE:
  - ir[15]=0 (A-instruction) -> COMMIT.
  - C-instruction with ir[12]=1 -> MEMRD.
  - Otherwise -> EXEC.
- MEMRD: mem_req=1, addr_sel=1, m_load=mem_ack. On ack -> EXEC.
- EXEC: one settle cycle for the ALU. ir[3] (d3=M) -> MWRITE, else -> COMMIT.
- MWRITE: mem_req=1, mem_we=1, addr_sel=1. On ack -> COMMIT.
- COMMIT (exactly 1 cycle):
  - A-instruction: a_load=1, a_src=0, pc_inc=1.
  - C-instruction: a_load=ir[5], a_src=1, d_load=ir[4].
  - C-instruction jump: cond = jump function of ir[2:0] with (alu_zr, alu_ng): 000 never, 001 >0, 010 =0, 011 >=0, 100 <0, 101 !=0, 110 <=0, 111 always. pc_load=cond, pc_inc=~cond.
  - All loads share one edge, so the PC jump target and the M write address use A before update. The ALU flags stay stable because no register changes before COMMIT.
  - Exit: run=1 -> FETCH, else -> IDLE.
- Exactly one of pc_load/pc_inc is high in COMMIT; both are 0 elsewhere.
- Latency with zero-wait ack:
  - A-instruction: 3 cycles.
  - C-instruction: 4 cycles, +1 with a=1, +1 with d3=1.
- Timeout:
  - The wait counter increments each cycle mem_req=1 && mem_ack=0, and clears on ack or state change.
  - At counter==TIMEOUT_CYC (TIMEOUT_CYC!=0) -> FAULT: mem_req=0, fault=1, no commit.
  - FAULT is left only by reset.
- run dropping mid-instruction has no effect until COMMIT completes.

Optional Feature:
- Macro: CPU_SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt[31:0], reset to 0, +1 on every COMMIT cycle, wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package cpu_pkg:
  - state_t enum (3-bit, encodings above).
  - Jump-code constants JMP_NULL..JMP_ALWAYS.
  - IR bit-index constants (IR_CI=15, IR_A=12, IR_D1=5, IR_D2=4, IR_D3=3).
- Sub-module jmp_eval: combinational (jmp[2:0], zr, ng) -> cond, instantiated once for COMMIT.

Test Plan:
- Reset then run=1, ack tied 1, ir=0x0005 -> states 1,2,6; a_load=1 with a_src=0 and pc_inc=1 in cycle 3; back to FETCH.
- ir=0xEC10 (D=A, a=0), ack 1 -> 4-cycle instruction; d_load=1, a_load=0, pc_inc=1 in COMMIT; no MEMRD/MWRITE.
- ir=0xFC88 (M=M-1: a=1, d3=1), ack delayed 2 cycles per request -> MEMRD and MWRITE each hold req 3 cycles; mem_we=1 only in MWRITE; addr_sel=1 in both.
- ir=0xE302 (D;JEQ-style code 010): alu_zr=1 -> pc_load=1, pc_inc=0; repeat with alu_zr=0 -> pc_inc=1. Sweep all 8 jump codes × {zr,ng} ∈ {00,01,10}.
- TIMEOUT_CYC=4, ack held 0 in FETCH -> FAULT after 4 wait cycles, fault=1, mem_req=0, busy=0; stays there until rst_n pulse.
- Assert rst_n=0 during MWRITE -> all outputs 0 immediately, state_o=0, no COMMIT; with CPU_SEQ_RETIRE_CNT_EN, retire_cnt=0 after reset and =N after N instructions.
